// File: rtl/compressor_error_monitor.sv
// Error-metric monitor for exact/approximate 8:2 compressor result pairs.
// Accepts N_SAMPLES pairs per run and accumulates count, distance, max and first failure.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             one-cycle pulse; clears metrics and starts a run (ignored in RUN)
//   in_valid/in_ready sample handshake; in_ready is high only in RUN
//   in_vector         compressor input pattern tagged to the sample
//   exact_sum         exact compressor output
//   approx_sum        approximate compressor output
//   busy / done       state flags for RUN / DONE
//   sample_count      samples accepted in the current or last run
//   err_count         samples whose sums differ
//   abs_err_total     sum of |exact - approx|
//   max_abs_err       largest |exact - approx|
//   first_err_vector  in_vector of the first mismatch (0 if none)
//   first_err_valid   a mismatch has been recorded this run
//   err_bias_sum      signed sum of (exact - approx); only with ERR_MON_SIGNED_BIAS_EN
//
// Optional feature macro: ERR_MON_SIGNED_BIAS_EN

module compressor_error_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 2,
    parameter int VEC_W     = 8,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VEC_W-1:0]         in_vector,
    input  logic [SUM_W-1:0]         exact_sum,
    input  logic [SUM_W-1:0]         approx_sum,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         sample_count,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W+SUM_W-1:0]   abs_err_total,
    output logic [SUM_W-1:0]         max_abs_err,
    output logic [VEC_W-1:0]         first_err_vector,
`ifdef ERR_MON_SIGNED_BIAS_EN
    output logic signed [CNT_W+SUM_W:0] err_bias_sum,
`endif
    output logic                     first_err_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t state;
    state_t state_n;

    logic             accept;
    logic             last;
    logic             clear;
    logic             is_err;
    logic [SUM_W-1:0] abs_err;

    assign accept = in_valid & in_ready;
    assign last   = (sample_count == LAST_CNT);
    assign clear  = start & (state != RUN);

    // Magnitude taken by ordered subtraction; equal to |d| of the
    // SUM_W+1-bit signed difference and never needs the extra bit.
    assign abs_err = (exact_sum >= approx_sum) ?
                     (exact_sum - approx_sum) :
                     (approx_sum - exact_sum);
    assign is_err  = (abs_err != '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (accept && last) state_n = DONE;
            end
            DONE: begin
                if (start) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        in_ready = (state == RUN);
    end

    // Metric accumulators
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sample_count     <= '0;
            err_count        <= '0;
            abs_err_total    <= '0;
            max_abs_err      <= '0;
            first_err_vector <= '0;
            first_err_valid  <= 1'b0;
        end else if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            if (is_err) begin
                err_count     <= err_count + CNT_W'(1);
                abs_err_total <= abs_err_total + (CNT_W+SUM_W)'(abs_err);
            end
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
            if (is_err && !first_err_valid) begin
                first_err_vector <= in_vector;
                first_err_valid  <= 1'b1;
            end
        end
    end

`ifdef ERR_MON_SIGNED_BIAS_EN
    localparam int BIAS_W = CNT_W + SUM_W + 1;

    logic signed [SUM_W:0] diff;

    assign diff = $signed({1'b0, exact_sum}) - $signed({1'b0, approx_sum});

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err_bias_sum <= '0;
        end else if (accept) begin
            err_bias_sum <= err_bias_sum + BIAS_W'(diff);
        end
    end
`endif

endmodule

// File: tb/tb_compressor_error_monitor.sv
// Scoreboard bench for compressor_error_monitor.
// Expected end-of-run metrics are queued by stimulus and checked when done rises.

module tb_compressor_error_monitor;

    localparam int N   = 256;
    localparam int SW  = 2;
    localparam int VW  = 8;
    localparam int CW  = $clog2(N + 1);
    localparam int N4  = 4;
    localparam int CW4 = $clog2(N4 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_vector = '0;
    logic [SW-1:0] exact_sum = '0;
    logic [SW-1:0] approx_sum = '0;
    logic          busy, done;
    logic [CW-1:0] sample_count, err_count;
    logic [CW+SW-1:0] abs_err_total;
    logic [SW-1:0] max_abs_err;
    logic [VW-1:0] first_err_vector;
    logic          first_err_valid;
    logic signed [CW+SW:0] err_bias_sum;

    logic          start4 = 1'b0;
    logic          in_valid4 = 1'b0;
    logic          in_ready4;
    logic [VW-1:0] in_vector4 = '0;
    logic [SW-1:0] exact_sum4 = '0;
    logic [SW-1:0] approx_sum4 = '0;
    logic          busy4, done4;
    logic [CW4-1:0] sample_count4, err_count4;
    logic [CW4+SW-1:0] abs_err_total4;
    logic [SW-1:0] max_abs_err4;
    logic [VW-1:0] first_err_vector4;
    logic          first_err_valid4;
    logic signed [CW4+SW:0] err_bias_sum4;

`ifndef ERR_MON_SIGNED_BIAS_EN
    assign err_bias_sum  = '0;
    assign err_bias_sum4 = '0;
`endif

    compressor_error_monitor #(.N_SAMPLES(N), .SUM_W(SW), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vector(in_vector), .exact_sum(exact_sum),
        .approx_sum(approx_sum), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count),
        .abs_err_total(abs_err_total), .max_abs_err(max_abs_err),
        .first_err_vector(first_err_vector),
`ifdef ERR_MON_SIGNED_BIAS_EN
        .err_bias_sum(err_bias_sum),
`endif
        .first_err_valid(first_err_valid)
    );

    compressor_error_monitor #(.N_SAMPLES(N4), .SUM_W(SW), .VEC_W(VW)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_vector(in_vector4), .exact_sum(exact_sum4),
        .approx_sum(approx_sum4), .busy(busy4), .done(done4),
        .sample_count(sample_count4), .err_count(err_count4),
        .abs_err_total(abs_err_total4), .max_abs_err(max_abs_err4),
        .first_err_vector(first_err_vector4),
`ifdef ERR_MON_SIGNED_BIAS_EN
        .err_bias_sum(err_bias_sum4),
`endif
        .first_err_valid(first_err_valid4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int err;
        int tot;
        int mx;
        int fev;
        int fevv;
        int bias;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    exp_t me;
    exp_t me4;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int c, int e, int t, int m, int fv, int fvv, int b);
        exp_t x;
        x.cnt = c; x.err = e; x.tot = t; x.mx = m;
        x.fev = fv; x.fevv = fvv; x.bias = b;
        return x;
    endfunction

    // Monitors: compare queued expectations on each rising done
    logic done_q = 1'b0;
    logic done4_q = 1'b0;

    always @(negedge clk) begin
        if (done && !done_q) begin
            chk("sb_has_entry", longint'(q.size() > 0), 1);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("sample_count", sample_count, me.cnt);
                chk("err_count", err_count, me.err);
                chk("abs_err_total", abs_err_total, me.tot);
                chk("max_abs_err", max_abs_err, me.mx);
                chk("first_err_vector", first_err_vector, me.fev);
                chk("first_err_valid", first_err_valid, me.fevv);
`ifdef ERR_MON_SIGNED_BIAS_EN
                chk("err_bias_sum", longint'(err_bias_sum), me.bias);
`endif
            end
        end
        done_q = done;
    end

    always @(negedge clk) begin
        if (done4 && !done4_q) begin
            chk("sb4_has_entry", longint'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                me4 = q4.pop_front();
                chk("n4_sample_count", sample_count4, me4.cnt);
                chk("n4_err_count", err_count4, me4.err);
                chk("n4_abs_err_total", abs_err_total4, me4.tot);
                chk("n4_max_abs_err", max_abs_err4, me4.mx);
                chk("n4_first_err_vector", first_err_vector4, me4.fev);
                chk("n4_first_err_valid", first_err_valid4, me4.fevv);
`ifdef ERR_MON_SIGNED_BIAS_EN
                chk("n4_err_bias_sum", longint'(err_bias_sum4), me4.bias);
`endif
            end
        end
        done4_q = done4;
    end

    task automatic send(input int v, input int e, input int a);
        in_valid   = 1'b1;
        in_vector  = v[VW-1:0];
        exact_sum  = e[SW-1:0];
        approx_sum = a[SW-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            in_valid   = 1'b0;
            in_vector  = VW'($urandom);
            exact_sum  = SW'($urandom);
            approx_sum = SW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_sample_count"}, sample_count, 0);
        chk({nm, "_err_count"}, err_count, 0);
        chk({nm, "_abs_err_total"}, abs_err_total, 0);
        chk({nm, "_max_abs_err"}, max_abs_err, 0);
        chk({nm, "_first_err_vector"}, first_err_vector, 0);
        chk({nm, "_first_err_valid"}, first_err_valid, 0);
    endtask

    task automatic check_end(input string nm);
        chk({nm, "_done_latency"}, done, 1);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_in_ready_low"}, in_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle_cyc(2);
        check_zero("idle");

        // Run 1: all samples equal
        q.push_back(mk(256, 0, 0, 0, 0, 0, 0));
        pulse_start();
        chk("run1_busy", busy, 1);
        for (int k = 0; k < N; k++) send(k, k & 3, k & 3);
        check_end("run1");

        // Run 2: two mismatches at 0x2A and 0x80
        q.push_back(mk(256, 2, 4, 3, 8'h2A, 1, 2));
        pulse_start();
        for (int k = 0; k < N; k++) begin
            if (k == 8'h2A) send(k, 3, 0);
            else if (k == 8'h80) send(k, 1, 2);
            else send(k, k & 3, k & 3);
        end
        check_end("run2");
        for (int k = 0; k < 3; k++) send(k + 1, 3, 0);
        chk("post_done_count", sample_count, 256);
        chk("post_done_err", err_count, 2);
        chk("post_done_ready", in_ready, 0);

        // Run 3: 1,0,0,1 valid pattern; errors at k=10,74,138,202
        q.push_back(mk(256, 4, 8, 2, 8'h0A, 1, 8));
        pulse_start();
        for (int k = 0; k < N; k++) begin
            if (k % 64 == 10) send(k, 2, 0);
            else send(k, 1, 1);
            if (k % 2 == 0 && k != N - 1) idle_cyc(2);
        end
        check_end("run3");

        // Run 4: reset after 100 accepts with 5 errors
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            if (k % 20 == 5) send(k, 3, 1);
            else send(k, 2, 2);
        end
        chk("mid_count", sample_count, 100);
        chk("mid_err", err_count, 5);
        chk("mid_total", abs_err_total, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        rst_n = 1'b1;
        idle_cyc(1);
        q.push_back(mk(256, 0, 0, 0, 0, 0, 0));
        pulse_start();
        for (int k = 0; k < N; k++) send(k, 0, 0);
        check_end("clean");

        // Run 5: start at sample 50 ignored; one error at 0xC8
        q.push_back(mk(256, 1, 3, 3, 8'hC8, 1, -3));
        pulse_start();
        for (int k = 0; k < N; k++) begin
            start = (k == 50);
            if (k == 200) send(k, 0, 3);
            else send(k, 3, 3);
        end
        start = 1'b0;
        check_end("run5");

        // start with in_valid from DONE: sample not taken
        start      = 1'b1;
        in_valid   = 1'b1;
        in_vector  = 8'h55;
        exact_sum  = 2'd3;
        approx_sum = 2'd0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        chk("restart_count", sample_count, 0);
        chk("restart_err", err_count, 0);
        chk("restart_total", abs_err_total, 0);
        chk("restart_fev", first_err_valid, 0);

        // N_SAMPLES=4, every sample 3 vs 0
        q4.push_back(mk(4, 4, 12, 3, 8'h11, 1, 12));
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        for (int k = 0; k < N4; k++) begin
            in_valid4   = 1'b1;
            in_vector4  = 8'(8'h11 + k);
            exact_sum4  = 2'd3;
            approx_sum4 = 2'd0;
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        chk("n4_done_latency", done4, 1);
        chk("n4_in_ready_low", in_ready4, 0);
        repeat (3) @(negedge clk);

        chk("sb_drained", q.size() + q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
